// File: rtl/imem.sv
// Byte-wide instruction memory serving 16-byte block reads to the instruction cache
// after a fixed latency, with a byte load port for writing the program beforehand.
module imem #(
  parameter int READ_LATENCY = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [5:0]   address,
  output logic [127:0] readdata,
  output logic         busywait,
  input  logic         load_en,
  input  logic [9:0]   load_addr,
  input  logic [7:0]   load_data
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state;
  logic [3:0]   counter;
  logic [5:0]   block_addr;
  logic [7:0]   mem [0:1023];
  logic [127:0] block_data;

  // Memory contents deliberately have no reset so a loaded program survives it.
  always_ff @(posedge clock) begin
    if (!reset && state == IDLE && !read && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    block_data = '0;
    for (int k = 0; k < 16; k++) begin
      block_data[8*k +: 8] = mem[{block_addr, 4'(k)}];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= 4'd0;
      block_addr <= 6'd0;
      busywait   <= 1'b0;
      readdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (read) begin
            block_addr <= address;
            counter    <= 4'(READ_LATENCY - 1);
            busywait   <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (counter != 4'd0) begin
            counter <= counter - 4'd1;
          end else begin
            readdata <= block_data;
            busywait <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          // Wait for the cache to drop read so a lingering request is not re-served.
          if (!read) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          busywait <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem.md
# imem

Instruction memory that backs the 128-byte instruction cache: a 1024 x 8-bit byte array answering 16-byte block reads with a fixed, parameterised latency and a busywait handshake. It sits directly downstream of the instruction cache, which drives `read` and a 6-bit block address and consumes the 128-bit block when `busywait` falls. A byte-wide load port lets the testbench or boot logic write the program before execution.

## Interface
- `READ_LATENCY`, 4: clock edges from request acceptance to data valid; legal range 1..15.
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high.
- `read`  in  1  block read request; held high until `busywait` falls.
- `address`  in  6  block address; byte base = {address, 4'h0}.
- `readdata`  out  128  block data; byte k of block at bits [8k+7:8k].
- `busywait`  out  1  high while a read is in flight.
- `load_en`  in  1  program-load byte write strobe.
- `load_addr`  in  10  byte address for load.
- `load_data`  in  8  byte to write.

## Operation
- Storage: 1024 bytes. Not cleared by reset; contents survive reset.
- Byte order: little-endian. `readdata[31:0]` = bytes base+3..base+0. This makes word offsets 0/4/8/12 map to bits [31:0]/[63:32]/[95:64]/[127:96].
- FSM states:
  - IDLE: `busywait`=0.
    - `read`=1 at an edge: latch `address`, set counter=READ_LATENCY-1, set `busywait`=1, go to BUSY.
    - Otherwise, if `load_en`=1: write `load_data` to mem[`load_addr`].
  - BUSY: `busywait`=1.
    - Counter≠0: decrement.
    - Counter=0: load `readdata` from the latched block, clear `busywait`, go to DONE.
  - DONE: `busywait`=0, `readdata` held. Go to IDLE at the first edge where `read`=0. Requests are not re-accepted while `read` stays high, which covers the cache's extra cycle of `mem_read` after busywait falls.
- `address` changes during BUSY/DONE are ignored; the latched address is used.
- Simultaneous `read`=1 and `load_en`=1 in IDLE: read is accepted, load is dropped.
- `load_en` in BUSY/DONE is dropped and memory is unchanged.
- A block read never wraps: all 16 bytes come from one block. Address 63 covers bytes 1008..1023.

## Timing
- Reset values: `busywait`=0, `readdata`=128'h0, state IDLE, counter 0.
- Request sampled at edge E0 (IDLE, `read`=1): `busywait`=1 from just after E0.
- At edge E0+READ_LATENCY: `readdata` updated and `busywait`=0 in the same edge. Data is stable before `busywait` falls as seen by the consumer.
- `readdata` changes only at a completing edge or at reset. It is held through DONE and IDLE until the next completion.
- Back-to-back: the earliest next acceptance is the edge after `read` is sampled low in DONE. Minimum request period is READ_LATENCY+2 edges.
- Reset mid-BUSY at edge R: the read is aborted, `busywait`=0, `readdata`=0, state IDLE. Memory is untouched, and a still-high `read` is re-accepted at edge R+1.
- Load write takes effect at the sampling edge. A read accepted at the next edge returns the new byte.

## Test plan
- Reset then idle: `reset`=1 for 2 edges → `busywait`=0, `readdata`=0. Preloaded bytes unchanged after reset.
- Load and read, READ_LATENCY=4: load bytes 0x00..0x0F into addresses 0x010..0x01F, then `read`=1, `address`=1. Expect `busywait` high for exactly 4 edges, then `readdata`=128'h0F0E0D0C0B0A09080706050403020100.
- Held read: keep `read`=1 for 3 edges after completion → exactly one transaction, `busywait` stays 0. Drop `read` for 1 edge, raise it with `address`=2 → a second transaction starts.
- Mid-flight changes: change `address` 1→5 and pulse `load_en` at 0x015 during BUSY → block 1 data returned, mem[0x015] unchanged.
- Reset abort: `reset`=1 on the 2nd BUSY edge → next cycle `busywait`=0, `readdata`=0. With `read` still high, a new transaction completes READ_LATENCY edges after reset is released.
- Boundary: `address`=63 with bytes 1008..1023 = 0xF0..0xFF → `readdata`[7:0]=0xF0, [127:120]=0xFF. Repeat with READ_LATENCY=1: one busy edge.
